// File: rtl/insn_fetch_responder_pkg.sv
// Shared types and address helpers for the instruction fetch responder.
package tachyon_ifetch_pkg;

  localparam int INSN_WIDTH = 32;
  // Address helpers work on a zero-extended word address; ADDR_WIDTH-2 must not exceed this.
  localparam int SPLIT_W    = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } fetch_state_e;

  function automatic int line_off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic logic [SPLIT_W-1:0] line_tag(input logic [SPLIT_W-1:0] waddr,
                                                  input int off_w);
    return waddr >> off_w;
  endfunction

  function automatic logic [SPLIT_W-1:0] line_offset(input logic [SPLIT_W-1:0] waddr,
                                                     input int off_w);
    return waddr & ((SPLIT_W'(1) << off_w) - SPLIT_W'(1));
  endfunction

endpackage

// File: rtl/insn_fetch_responder_if.sv
// Fetch-side and memory-side handshake bundle of the instruction fetch responder.
interface insn_fetch_responder_if
  import tachyon_ifetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 4
);
  localparam int OFF_W = line_off_w(LINE_WORDS);

  logic                           fetch_en;
  logic [ADDR_WIDTH-3:0]          fetch_addr;
  logic                           fetch_busy;
  logic                           fetch_insn_valid;
  logic [INSN_WIDTH-1:0]          fetch_insn;
  logic                           flush;
  logic                           mem_req_valid;
  logic                           mem_req_ready;
  logic [ADDR_WIDTH-3-OFF_W:0]    mem_req_addr;
  logic                           mem_rsp_valid;
  logic [INSN_WIDTH-1:0]          mem_rsp_data;

  modport slave (
    input  fetch_en, fetch_addr, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output fetch_busy, fetch_insn_valid, fetch_insn, mem_req_valid, mem_req_addr
  );

  modport master (
    output fetch_en, fetch_addr, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  fetch_busy, fetch_insn_valid, fetch_insn, mem_req_valid, mem_req_addr
  );

endinterface

// File: rtl/insn_fetch_responder_line_buf.sv
// Single cached line: word array with one write port and a combinational read, plus tag/valid.
module fetch_line_buf
  import tachyon_ifetch_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int OFF_W      = 2,
  parameter int TAG_W      = 28
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [OFF_W-1:0]      widx_i,
  input  logic [INSN_WIDTH-1:0] wdata_i,
  input  logic [OFF_W-1:0]      ridx_i,
  output logic [INSN_WIDTH-1:0] rdata_o,
  input  logic                  tag_we_i,
  input  logic [TAG_W-1:0]      tag_i,
  input  logic                  tag_valid_i,
  input  logic                  inval_i,
  output logic [TAG_W-1:0]      tag_o,
  output logic                  valid_o
);

  logic [INSN_WIDTH-1:0] word_q [LINE_WORDS];
  logic [TAG_W-1:0]      tag_q;
  logic                  valid_q;

  always_ff @(posedge clk) begin
    if (we_i) word_q[widx_i] <= wdata_i;
    if (tag_we_i) tag_q <= tag_i;
  end

  // A tag write decides validity on its own; an invalidate only acts otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           valid_q <= 1'b0;
    else if (tag_we_i) valid_q <= tag_valid_i;
    else if (inval_i)  valid_q <= 1'b0;
  end

  assign rdata_o = word_q[ridx_i];
  assign tag_o   = tag_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/insn_fetch_responder.sv
// One-line instruction responder: 1-cycle hits, valid/ready line request, beat-serial refill.
module insn_fetch_responder
  import tachyon_ifetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 4
)(
  input  logic                  clk,
  input  logic                  rst,
  insn_fetch_responder_if.slave bus
);

  localparam int              WA_W      = ADDR_WIDTH - 2;
  localparam int              OFF_W     = line_off_w(LINE_WORDS);
  localparam int              TAG_W     = WA_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  fetch_state_e          state_q, state_d;
  logic [OFF_W-1:0]      beat_q, beat_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  req_valid_q, req_valid_d;
  logic [TAG_W-1:0]      req_addr_q, req_addr_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic                  insn_valid_q, insn_valid_d;
  logic [INSN_WIDTH-1:0] insn_q, insn_d;

  logic [TAG_W-1:0]      fetch_tag, buf_tag;
  logic [OFF_W-1:0]      fetch_off, rd_idx;
  logic [INSN_WIDTH-1:0] rd_word;
  logic                  buf_valid, hit;
  logic                  buf_we, tag_we, tag_valid, inval;

  assign fetch_tag = TAG_W'(line_tag(SPLIT_W'(bus.fetch_addr), OFF_W));
  assign fetch_off = OFF_W'(line_offset(SPLIT_W'(bus.fetch_addr), OFF_W));
  // A same-cycle flush forces a miss so the fetch never sees the line being invalidated.
  assign hit       = buf_valid && (buf_tag == fetch_tag) && !bus.flush;
  assign rd_idx    = (state_q == IDLE) ? fetch_off : off_q;

  fetch_line_buf #(
    .LINE_WORDS(LINE_WORDS),
    .OFF_W     (OFF_W),
    .TAG_W     (TAG_W)
  ) u_line (
    .clk        (clk),
    .rst        (rst),
    .we_i       (buf_we),
    .widx_i     (beat_q),
    .wdata_i    (bus.mem_rsp_data),
    .ridx_i     (rd_idx),
    .rdata_o    (rd_word),
    .tag_we_i   (tag_we),
    .tag_i      (req_addr_q),
    .tag_valid_i(tag_valid),
    .inval_i    (inval),
    .tag_o      (buf_tag),
    .valid_o    (buf_valid)
  );

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    flush_pend_d = flush_pend_q;
    req_valid_d  = req_valid_q;
    req_addr_d   = req_addr_q;
    off_d        = off_q;
    insn_valid_d = 1'b0;
    insn_d       = insn_q;
    buf_we       = 1'b0;
    tag_we       = 1'b0;
    tag_valid    = 1'b0;
    inval        = 1'b0;
    case (state_q)
      IDLE: begin
        inval = bus.flush;
        if (bus.fetch_en) begin
          if (hit) begin
            insn_valid_d = 1'b1;
            insn_d       = rd_word;
          end else begin
            state_d     = REQ;
            req_valid_d = 1'b1;
            req_addr_d  = fetch_tag;
            off_d       = fetch_off;
          end
        end
      end
      REQ: begin
        if (bus.flush) flush_pend_d = 1'b1;
        if (bus.mem_req_ready) begin
          req_valid_d = 1'b0;
          beat_d      = '0;
          state_d     = FILL;
        end
      end
      FILL: begin
        if (bus.flush) flush_pend_d = 1'b1;
        if (bus.mem_rsp_valid) begin
          buf_we = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            tag_we    = 1'b1;
            tag_valid = ~(flush_pend_q | bus.flush);
            state_d   = RESP;
          end
        end
      end
      RESP: begin
        inval        = bus.flush;
        insn_valid_d = 1'b1;
        insn_d       = rd_word;
        flush_pend_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      insn_valid_q <= 1'b0;
      insn_q       <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      flush_pend_q <= flush_pend_d;
      req_valid_q  <= req_valid_d;
      req_addr_q   <= req_addr_d;
      insn_valid_q <= insn_valid_d;
      insn_q       <= insn_d;
    end
  end

  always_ff @(posedge clk) off_q <= off_d;

  assign bus.fetch_busy       = (state_q != IDLE);
  assign bus.fetch_insn_valid = insn_valid_q;
  assign bus.fetch_insn       = insn_q;
  assign bus.mem_req_valid    = req_valid_q;
  assign bus.mem_req_addr     = req_addr_q;

endmodule

// File: tb/tb_insn_fetch_responder.sv
// Directed bench for insn_fetch_responder with LINE_WORDS=4 and 32-bit addresses.
module tb_insn_fetch_responder;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  insn_fetch_responder_if #(.ADDR_WIDTH(32), .LINE_WORDS(4)) bus ();

  insn_fetch_responder #(.ADDR_WIDTH(32), .LINE_WORDS(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Full miss: issue, optional request stall (with stray beats), 4 beats, delivery check.
  task automatic do_miss(input logic [29:0] waddr, input logic [31:0] d0, input int stall,
                         input int flush_beat, input logic flush_at_issue, input string nm);
    bus.fetch_en   = 1'b1;
    bus.fetch_addr = waddr;
    bus.flush      = flush_at_issue;
    @(negedge clk);
    bus.fetch_en = 1'b0;
    bus.flush    = 1'b0;
    chk({nm, ".req_v"}, 32'(bus.mem_req_valid), 1);
    chk({nm, ".req_a"}, 32'(bus.mem_req_addr), 32'(waddr >> 2));
    chk({nm, ".busy"},  32'(bus.fetch_busy), 1);
    for (int s = 0; s < stall; s++) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'hDEAD_0000 + 32'(s);
      @(negedge clk);
      chk({nm, ".stall_req_v"}, 32'(bus.mem_req_valid), 1);
      chk({nm, ".stall_req_a"}, 32'(bus.mem_req_addr), 32'(waddr >> 2));
    end
    bus.mem_rsp_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    chk({nm, ".req_v_drop"}, 32'(bus.mem_req_valid), 0);
    for (int i = 0; i < 4; i++) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = d0 + 32'(i);
      bus.flush         = (i == flush_beat);
      @(negedge clk);
    end
    bus.mem_rsp_valid = 1'b0;
    bus.flush         = 1'b0;
    chk({nm, ".resp_busy"},  32'(bus.fetch_busy), 1);
    chk({nm, ".resp_valid"}, 32'(bus.fetch_insn_valid), 0);
    @(negedge clk);
    chk({nm, ".valid"}, 32'(bus.fetch_insn_valid), 1);
    chk({nm, ".insn"},  bus.fetch_insn, d0 + 32'(waddr[1:0]));
    chk({nm, ".idle"},  32'(bus.fetch_busy), 0);
  endtask

  task automatic do_hit(input logic [29:0] waddr, input logic [31:0] exp, input string nm);
    bus.fetch_en   = 1'b1;
    bus.fetch_addr = waddr;
    @(negedge clk);
    chk({nm, ".valid"}, 32'(bus.fetch_insn_valid), 1);
    chk({nm, ".insn"},  bus.fetch_insn, exp);
    chk({nm, ".no_req"}, 32'(bus.mem_req_valid), 0);
    chk({nm, ".busy"},  32'(bus.fetch_busy), 0);
  endtask

  initial begin
    rst               = 1'b1;
    bus.fetch_en      = 1'b0;
    bus.fetch_addr    = '0;
    bus.flush         = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.busy",  32'(bus.fetch_busy), 0);
    chk("rst.valid", 32'(bus.fetch_insn_valid), 0);
    chk("rst.insn",  bus.fetch_insn, 0);
    chk("rst.req_v", 32'(bus.mem_req_valid), 0);
    chk("rst.req_a", 32'(bus.mem_req_addr), 0);
    rst = 1'b0;
    @(negedge clk);

    do_miss(30'h400, 32'hA0, 0, -1, 1'b0, "cold");
    do_hit(30'h401, 32'hA1, "hit1");
    do_hit(30'h402, 32'hA2, "hit2");
    do_hit(30'h403, 32'hA3, "hit3");
    bus.fetch_en = 1'b0;
    @(negedge clk);
    chk("idle.valid", 32'(bus.fetch_insn_valid), 0);
    chk("idle.hold",  bus.fetch_insn, 32'hA3);

    do_miss(30'h404, 32'hB0, 5, -1, 1'b0, "wrap_bp");
    do_hit(30'h405, 32'hB1, "wrap_hit");

    do_miss(30'h400, 32'hC0, 0, 2, 1'b0, "flush_fill");
    do_miss(30'h401, 32'hD0, 0, -1, 1'b0, "refetch");
    do_hit(30'h403, 32'hD3, "refetch_hit");

    bus.fetch_en = 1'b0;
    bus.flush    = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    do_miss(30'h402, 32'hF0, 0, -1, 1'b0, "flush_idle");
    do_miss(30'h403, 32'h50, 0, -1, 1'b1, "flush_same");
    do_hit(30'h400, 32'h50, "same_hit");

    bus.fetch_addr = 30'h500;
    @(negedge clk);
    bus.fetch_en = 1'b0;
    chk("rstf.req_a", 32'(bus.mem_req_addr), 32'h140);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h70;
    @(negedge clk);
    bus.mem_rsp_data  = 32'h71;
    @(negedge clk);
    bus.mem_rsp_data  = 32'h72;
    rst = 1'b1;
    #1;
    chk("rstf.busy",  32'(bus.fetch_busy), 0);
    chk("rstf.valid", 32'(bus.fetch_insn_valid), 0);
    chk("rstf.insn",  bus.fetch_insn, 0);
    chk("rstf.req_v", 32'(bus.mem_req_valid), 0);
    chk("rstf.req_a", 32'(bus.mem_req_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.mem_rsp_data = 32'h73;
    @(negedge clk);
    @(negedge clk);
    chk("rstf.late_busy",  32'(bus.fetch_busy), 0);
    chk("rstf.late_req_v", 32'(bus.mem_req_valid), 0);
    chk("rstf.late_valid", 32'(bus.fetch_insn_valid), 0);
    bus.mem_rsp_valid = 1'b0;
    do_miss(30'h400, 32'h90, 0, -1, 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
